linebuf_writer: RTL

LINEBUF_WRITER -- requirements
Module: linebuf_writer

---
 rtl/linebuf_writer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/linebuf_writer.sv
// Scanline-buffer strip writer: each command performs eight read-check-write pixel slots.
// Define LBW_COLLISION_EN to enable the sticky collision flag; otherwise coll stays 0.
module linebuf_writer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [31:0] cmd_pix,
    input  logic [6:0]  cmd_pal,
    input  logic        cmd_flip,
    output logic [9:0]  lb_adr,
    output logic [10:0] lb_wdat,
    output logic        lb_we,
    input  logic [10:0] lb_rdat,
    input  logic        coll_clr,
    output logic        coll
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_x;
    logic [31:0] r_pix;
    logic [6:0]  r_pal;
    logic        r_flip;
    logic [2:0]  r_idx;

    logic [2:0]  w_pixIdx;
    logic [3:0]  w_pix;
    logic [9:0]  w_adr;
    logic        w_opaque;
    logic        w_occupied;
    logic        w_hit;

    // Flip mirrors the pixel order only; addresses still walk left to right.
    assign w_pixIdx   = r_flip ? (3'd7 - r_idx) : r_idx;
    assign w_pix      = r_pix[{w_pixIdx, 2'b00} +: 4];
    assign w_adr      = r_x + {7'd0, r_idx};
    assign w_opaque   = (w_pix != 4'd0);
    assign w_occupied = (lb_rdat[3:0] != 4'd0);
    assign w_hit      = (r_state == WR) && w_opaque && w_occupied;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_pix  <= '0;
            r_pal  <= '0;
            r_flip <= 1'b0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_x    <= cmd_x;
                        r_pix  <= cmd_pix;
                        r_pal  <= cmd_pal;
                        r_flip <= cmd_flip;
                        r_idx  <= '0;
                    end
                end
                WR:      r_idx <= r_idx + 3'd1;
                default: ;
            endcase
        end
    end

    // The readback registered during RD is valid in WR; an occupied slot is never overwritten.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        lb_adr    = '0;
        lb_wdat   = '0;
        lb_we     = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = RD;
                end
            end
            RD: begin
                lb_adr = w_adr;
                w_next = WR;
            end
            WR: begin
                lb_adr  = w_adr;
                lb_wdat = {r_pal, w_pix};
                lb_we   = w_opaque && !w_occupied;
                w_next  = (r_idx == 3'd7) ? IDLE : RD;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef LBW_COLLISION_EN
    logic r_coll;
    logic w_unused;

    // A collision in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll <= 1'b0;
        end else if (w_hit) begin
            r_coll <= 1'b1;
        end else if (coll_clr) begin
            r_coll <= 1'b0;
        end
    end

    assign coll     = r_coll;
    assign w_unused = ^lb_rdat[10:4];
`else
    logic w_unused;

    assign coll     = 1'b0;
    assign w_unused = ^{lb_rdat[10:4], coll_clr, w_hit};
`endif

endmodule
